// File: rtl/bus_arbiter_pkg.sv
// Shared CPU bus constants and the arbiter state encoding.
// Used by bus_arbiter (optional watchdog enabled with ARB_TIMEOUT_EN) and its rr_pick helper.
package bus_arbiter_pkg;

  localparam int WORD        = 32;
  localparam int WORD_ADDR_W = 30;
  localparam int NUM_M_DEF   = 4;

  localparam int M_IF  = 0;
  localparam int M_MEM = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first requester at or above ptr,
// wrapping modulo N, skipping any master set in the exclude mask.
module bus_arbiter_rr_pick
  import bus_arbiter_pkg::*;
#(
  parameter int N  = NUM_M_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  excl,
  output logic [IW-1:0] winner,
  output logic          found
);

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [N-1:0]  cand;
  logic [IW-1:0] idx;

  // Explicit wrap compare keeps the scan inside 0..N-1 for non-power-of-2 N.
  always_comb begin
    cand   = req & ~excl;
    found  = 1'b0;
    winner = '0;
    idx    = ptr;
    for (int k = 0; k < N; k++) begin
      if (!found && cand[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
      idx = (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner-holds arbiter for the shared CPU bus with owner datapath mux.
// Define ARB_TIMEOUT_EN to add the grant watchdog and the arb_timeout pulse output.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_M   = NUM_M_DEF,
  parameter int ADDR_W  = WORD_ADDR_W,
  parameter int DATA_W  = WORD,
  parameter int TIMEOUT = 255,
  parameter int IW      = $clog2(NUM_M)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_M-1:0]          m_req,
  input  logic [NUM_M*ADDR_W-1:0]   m_addr,
  input  logic [NUM_M-1:0]          m_as,
  input  logic [NUM_M-1:0]          m_rw,
  input  logic [NUM_M*DATA_W-1:0]   m_wr_data,
  output logic [NUM_M-1:0]          m_grnt,
  output logic [NUM_M-1:0]          m_rdy,
  output logic [DATA_W-1:0]         m_rd_data,
  output logic [ADDR_W-1:0]         s_addr,
  output logic                      s_as,
  output logic                      s_rw,
  output logic [DATA_W-1:0]         s_wr_data,
  input  logic [DATA_W-1:0]         s_rd_data,
  input  logic                      s_rdy,
  output logic [IW-1:0]             owner,
  output logic                      owner_vld
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                      arb_timeout
`endif
);

  localparam logic [IW-1:0] LAST = IW'(NUM_M - 1);

  if ((NUM_M < 2) || (NUM_M > 8) || (TIMEOUT < 1)) begin : g_bad_param
    $error("bus_arbiter: NUM_M must be 2..8 and TIMEOUT at least 1");
  end

  arb_state_e       state, state_n;
  logic [IW-1:0]    ptr, ptr_n, owner_n, owner_inc, pick_ptr, winner;
  logic [NUM_M-1:0] excl, grnt_n;
  logic             found, vld_n, release_now, timeout_hit;

  bus_arbiter_rr_pick #(.N(NUM_M), .IW(IW)) u_pick (
    .req    (m_req),
    .ptr    (pick_ptr),
    .excl   (excl),
    .winner (winner),
    .found  (found)
  );

  assign owner_vld = (state == ST_OWNED);

  // While owned, the only arbitration that matters is a release, which
  // restarts the scan just past the owner and never hands back to it.
  always_comb begin
    owner_inc = (owner == LAST) ? '0 : owner + 1'b1;
    pick_ptr  = (state == ST_OWNED) ? owner_inc : ptr;
    excl      = '0;
    if (state == ST_OWNED) excl[owner] = 1'b1;
  end

  assign release_now = (state == ST_OWNED) && (!m_req[owner] || timeout_hit);

  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
    vld_n   = owner_vld;
    grnt_n  = '0;
    case (state)
      ST_IDLE: begin
        if (found) begin
          state_n = ST_OWNED;
          owner_n = winner;
          vld_n   = 1'b1;
        end
      end
      ST_OWNED: begin
        if (release_now) begin
          ptr_n = owner_inc;
          if (found) begin
            owner_n = winner;
          end else begin
            state_n = ST_IDLE;
            vld_n   = 1'b0;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    for (int i = 0; i < NUM_M; i++) grnt_n[i] = vld_n && (owner_n == IW'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      owner  <= '0;
      ptr    <= '0;
      m_grnt <= '0;
    end else begin
      state  <= state_n;
      owner  <= owner_n;
      ptr    <= ptr_n;
      m_grnt <= grnt_n;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] to_cnt;

  // Revoke on the edge that completes the TIMEOUT-th owned cycle without rdy.
  assign timeout_hit = (state == ST_OWNED) && !s_rdy && (to_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt      <= '0;
      arb_timeout <= 1'b0;
    end else begin
      arb_timeout <= timeout_hit;
      if ((grnt_n != m_grnt) || s_rdy) to_cnt <= '0;
      else if (state == ST_OWNED)      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    s_addr    = '0;
    s_as      = 1'b0;
    s_rw      = 1'b0;
    s_wr_data = '0;
    if (owner_vld) begin
      s_addr    = m_addr[owner*ADDR_W +: ADDR_W];
      s_as      = m_as[owner];
      s_rw      = m_rw[owner];
      s_wr_data = m_wr_data[owner*DATA_W +: DATA_W];
    end
    for (int i = 0; i < NUM_M; i++) m_rdy[i] = s_rdy && owner_vld && (owner == IW'(i));
  end

  assign m_rd_data = s_rd_data;

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single CPU bus between NUM_M masters: IF-stage fetch, MEM-stage load/store, and up to two external masters.
- Each master runs the existing req/grnt/as/rdy handshake.
- Round-robin arbitration: one owner at a time, and the owner keeps the grant for as long as it holds req.
- Muxes the owner's address/control/write data onto the shared slave-side bus, and routes rdy back to the owner only.

Parameters:
- NUM_M, 4, number of masters (2..8); master 0 = IF, master 1 = MEM.
- ADDR_W, 30, word address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, watchdog limit in cycles (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- m_req  in  NUM_M  per-master bus request, active-high
- m_addr  in  NUM_M*ADDR_W  packed per-master address, master i at [i*ADDR_W +: ADDR_W]
- m_as  in  NUM_M  per-master address strobe, active-high, one cycle
- m_rw  in  NUM_M  per-master read(0)/write(1)
- m_wr_data  in  NUM_M*DATA_W  packed per-master write data
- m_grnt  out  NUM_M  one-hot grant, registered
- m_rdy  out  NUM_M  ready routed to owner only
- m_rd_data  out  DATA_W  slave read data, broadcast to all masters
- s_addr  out  ADDR_W  shared-bus address
- s_as  out  1  shared-bus address strobe
- s_rw  out  1  shared-bus read/write
- s_wr_data  out  DATA_W  shared-bus write data
- s_rd_data  in  DATA_W  slave read data
- s_rdy  in  1  slave ready
- owner  out  clog2(NUM_M)  current owner index, valid when owner_vld
- owner_vld  out  1  a grant is active

Behaviour:
- Reset (synchronous, active-high):
  - m_grnt=0, owner_vld=0, owner=0.
  - RR pointer=0, so master 0 has highest priority first.
  - All s_* outputs 0, m_rdy=0.
  - Reset mid-transfer drops the grant on the next edge; any in-flight access is abandoned.
- FSM, two states:
  - IDLE: no owner. If any m_req is high at an edge, go to OWNED.
    - Winner = first requester scanning from ptr upward, wrapping modulo NUM_M.
    - m_grnt[winner]=1 and owner=winner, both registered.
    - Latency: req sampled at edge t gives grnt visible after edge t+1's setup, i.e. one cycle.
  - OWNED: grant held while m_req[owner]=1; other requests are ignored, no preemption.
    - When m_req[owner]=0 at an edge: ptr<=owner+1 (mod NUM_M).
    - Re-arbitrate in the same edge among the remaining requests, excluding the releasing owner.
    - If another requester exists: go directly to OWNED with the new owner. Handover has zero dead cycles.
    - If none: go to IDLE with m_grnt=0.
- Simultaneous requests: RR order decides. A master that drops and re-raises req in consecutive cycles goes behind all other pending requesters.
- Datapath mux (combinational from registered owner):
  - When owner_vld: s_addr/s_as/s_rw/s_wr_data = the owner's slice.
  - When not owner_vld: all 0.
  - s_as is forced 0 for non-owners even if they assert m_as.
- m_rdy[i] = s_rdy & owner_vld & (owner==i). m_rd_data = s_rd_data unconditionally.
- Protocol the masters must follow: assert req; wait for grnt; pulse as one cycle; wait for rdy; drop req. Back-to-back accesses by one master while it keeps req high are legal.
- Index arithmetic: ptr and owner are clog2(NUM_M) bits. Wrap uses an explicit compare with NUM_M-1 so that non-power-of-2 NUM_M works.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on every grant change and on every s_rdy.
  - It increments each cycle in OWNED.
  - When it reaches TIMEOUT, the grant is revoked on that edge: a forced release, ptr advances, and arbitration proceeds as for a normal release.
  - A one-cycle pulse appears on extra output port arb_timeout (1 bit, reset 0).
- Undefined: no counter and no arb_timeout port; the owner holds the grant indefinitely.

Decomposition:
- Shared package/header holds the bus constants used across the CPU: WORD, WORD_ADDR_W, NUM_M default, master index constants (M_IF=0, M_MEM=1).
- One natural sub-module, rr_pick:
  - Purely combinational round-robin priority encoder.
  - Inputs: req vector, ptr, exclude mask.
  - Outputs: winner index and a found flag.
  - Verifiable standalone.

Test Plan:
- Reset then m_req=4'b0001 → m_grnt=0001 one cycle later. m_as[0] pulse with m_addr[0]=30'h100 → s_addr=30'h100, s_as=1 same cycle. s_rdy=1 → m_rdy=0001, m_rdy[1..3]=0.
- m_req=4'b0110 simultaneously from IDLE, ptr=0 → grant 0010. Master 1 drops req → next edge grant 0100 with no idle cycle. Master 2 drops → IDLE, m_grnt=0000.
- Master 0 holds req 20 cycles while m_req[3]=1 → m_grnt stays 0001 throughout, then 1000 one edge after m_req[0] falls.
- Non-owner master 2 asserts m_as with m_addr=30'h3FF while master 0 owns → s_addr shows master 0's address, m_rdy[2]=0 when s_rdy=1.
- rst=1 asserted while OWNED mid-access → next edge m_grnt=0, s_as=0, owner_vld=0. A fresh m_req=4'b1000 grants master 3 cleanly.
- With ARB_TIMEOUT_EN, TIMEOUT=8: owner 1 holds req, s_rdy never asserts, m_req[2]=1 → after 8 OWNED cycles arb_timeout pulses for one cycle and grant moves to 0100.
